// File: rtl/cdc_in_arbiter_pkg.sv
// rtl/cdc_in_arbiter_pkg.sv - shared states and constants for the CDC IN byte-stream arbiter
package cdc_in_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Full-speed bulk IN max packet size on the usb_cdc side.
  localparam int CDC_IN_MPS       = 64;
  localparam int DEF_MAX_BURST    = CDC_IN_MPS;
  localparam int DEF_IDLE_TIMEOUT = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_in_arbiter_rr_pick.sv
// rtl/cdc_in_arbiter_rr_pick.sv - combinational round-robin pick, searching from ptr+1
module rr_pick
  import cdc_in_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_in_arbiter.sv
// rtl/cdc_in_arbiter.sv - round-robin merge of N byte streams into the usb_cdc IN path
module cdc_in_arbiter
  import cdc_in_arbiter_pkg::*;
#(
  parameter int N_SRC        = 3,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*N_SRC-1:0] src_data_i,
  input  logic [N_SRC-1:0]   src_valid_i,
  input  logic [N_SRC-1:0]   src_last_i,
  output logic [N_SRC-1:0]   src_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_SRC-1:0]   grant_o,
  output logic               busy_o
);

  localparam int IW = idx_width(N_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t       state, state_n;
  logic [N_SRC-1:0] grant, pick;
  logic [IW-1:0]    gidx, pick_idx, last_grant;
  logic [CW-1:0]    count;
  logic [TW-1:0]    stall;
  logic [7:0]       out_data, sel_data;
  logic             out_full, sel_valid, sel_last;
  logic             ready_g, hs, drain, done;

  rr_pick #(.N(N_SRC), .PW(IW)) u_pick (
    .req (src_valid_i),
    .ptr (last_grant),
    .win (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N_SRC; k++)
      if (pick[k]) pick_idx = IW'(k);
  end

  always_comb begin
    sel_data  = 8'h00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (gidx == IW'(k)) begin
        sel_data  = src_data_i[8*k +: 8];
        sel_valid = src_valid_i[k];
        sel_last  = src_last_i[k];
      end
    end
  end

  // The output register accepts a new byte whenever it is empty or draining this cycle.
  assign ready_g = ~out_full | in_ready_i;
  assign hs      = (state == ST_BURST) & sel_valid & ready_g;
  assign drain   = out_full & in_ready_i;

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|src_valid_i) state_n = ST_BURST;
      end
      ST_BURST: begin
        if (hs)
          done = sel_last | ((count + 1'b1) == CW'(MAX_BURST));
        else if (!sel_valid)
          done = ((stall + 1'b1) == TW'(IDLE_TIMEOUT));
        if (done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(N_SRC - 1);
      count      <= '0;
      stall      <= '0;
      out_data   <= 8'h00;
      out_full   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && state_n == ST_BURST) begin
        grant <= pick;
        gidx  <= pick_idx;
        count <= '0;
        stall <= '0;
      end else if (state == ST_BURST) begin
        if (done) begin
          grant      <= '0;
          last_grant <= gidx;
          count      <= '0;
          stall      <= '0;
        end else if (hs) begin
          count <= count + 1'b1;
          stall <= '0;
        end else if (!sel_valid) begin
          stall <= stall + 1'b1;
        end
      end
      if (hs) begin
        out_data <= sel_data;
        out_full <= 1'b1;
      end else if (drain) begin
        out_full <= 1'b0;
      end
    end
  end

  assign src_ready_o = (state == ST_BURST) ? (grant & {N_SRC{ready_g}}) : '0;
  assign in_data_o   = out_data;
  assign in_valid_o  = out_full;
  assign grant_o     = grant;
  assign busy_o      = (state == ST_BURST) | out_full;

endmodule
